// File: rtl/vdp_super_fill.sv
`timescale 1ns/1ps
// Solid-colour rectangle filler for the super-res framebuffer: packs each row into 32-bit VRAM word writes.
// First request 2 cycles after start; one write outstanding, held until vram_ack; yields while super_res_drawing.
module vdp_super_fill #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vdp_super,
    input  logic              super_res_drawing,
    input  logic              start,
    input  logic [16:0]       ext_reg_super_res_page_addr,
    input  logic              ext_reg_pixel_depth,
    input  logic [9:0]        line_stride,
    input  logic [9:0]        dst_x,
    input  logic [9:0]        dst_y,
    input  logic [9:0]        width,
    input  logic [9:0]        height,
    input  logic [7:0]        colour,
    output logic              vram_req,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [31:0]       vram_wdata,
    output logic [3:0]        vram_be,
    input  logic              vram_ack,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_BUS,
        S_REQ,
        S_NEXT_ROW
    } state_t;

    state_t            state_q, state_d;
    logic [19:0]       base_q, base_d;
    logic [9:0]        stride_q, stride_d;
    logic [9:0]        ypos_q, ypos_d;
    logic [9:0]        xbyte_q, xbyte_d;
    logic [9:0]        nbytes_q, nbytes_d;
    logic [9:0]        rows_left_q, rows_left_d;
    logic [19:0]       row_addr_q, row_addr_d;
    logic [19:0]       cur_byte_q, cur_byte_d;
    logic [9:0]        rem_q, rem_d;
    logic [2:0]        n_q, n_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        off;
    logic [2:0]        room;
    logic [2:0]        n_w;
    logic [4:0]        be_mask;
    logic [3:0]        be_w;
    logic [19:0]       prod;
    logic [19:0]       row_start;
    logic [19:0]       next_row;
    logic [9:0]        rem_sub;
    logic [9:0]        nb_4bpp;
    logic [7:0]        fill_byte;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        stride_d    = stride_q;
        ypos_d      = ypos_q;
        xbyte_d     = xbyte_q;
        nbytes_d    = nbytes_q;
        rows_left_d = rows_left_q;
        row_addr_d  = row_addr_q;
        cur_byte_d  = cur_byte_q;
        rem_d       = rem_q;
        n_d         = n_q;
        req_d       = req_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        done_d      = 1'b0;

        // Bytes this word can take: limited by the lane offset and by what is left of the row.
        off       = cur_byte_q[1:0];
        room      = 3'd4 - {1'b0, off};
        n_w       = (rem_q < {7'd0, room}) ? rem_q[2:0] : room;
        be_mask   = (5'd1 << n_w) - 5'd1;
        be_w      = be_mask[3:0] << off;
        prod      = {10'd0, ypos_q} * {10'd0, stride_q};
        row_start = base_q + prod + {10'd0, xbyte_q};
        next_row  = row_addr_q + {10'd0, stride_q};
        rem_sub   = rem_q - {7'd0, n_q};
        nb_4bpp   = {1'b0, width[9:1]} + {9'd0, width[0]};
        fill_byte = ext_reg_pixel_depth ? {colour[3:0], colour[3:0]} : colour;

        case (state_q)
            S_IDLE: begin
                if (start && vdp_super) begin
                    if (width != 10'd0 && height != 10'd0) begin
                        base_d      = {ext_reg_super_res_page_addr, 3'b000};
                        stride_d    = line_stride;
                        ypos_d      = dst_y;
                        rows_left_d = height;
                        xbyte_d     = ext_reg_pixel_depth ? (dst_x >> 1) : dst_x;
                        nbytes_d    = ext_reg_pixel_depth ? nb_4bpp : width;
                        wdata_d     = {4{fill_byte}};
                        state_d     = S_SETUP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                row_addr_d = row_start;
                cur_byte_d = row_start;
                rem_d      = nbytes_q;
                state_d    = S_WAIT_BUS;
            end
            S_WAIT_BUS: begin
                if (!super_res_drawing) begin
                    n_d     = n_w;
                    be_d    = be_w;
                    addr_d  = ADDR_W'(cur_byte_q[19:2]);
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Scan-out rising here does not retract a request already on the bus.
                if (vram_ack) begin
                    req_d      = 1'b0;
                    rem_d      = rem_sub;
                    cur_byte_d = cur_byte_q + {17'd0, n_q};
                    if (!vdp_super) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (rem_sub == 10'd0) begin
                        state_d = S_NEXT_ROW;
                    end else begin
                        state_d = S_WAIT_BUS;
                    end
                end
            end
            S_NEXT_ROW: begin
                rows_left_d = rows_left_q - 10'd1;
                if (rows_left_q == 10'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    row_addr_d = next_row;
                    cur_byte_d = next_row;
                    rem_d      = nbytes_q;
                    state_d    = S_WAIT_BUS;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Losing super mode with nothing on the bus ends the command at once.
        if (!vdp_super && (state_q == S_SETUP || state_q == S_WAIT_BUS || state_q == S_NEXT_ROW)) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            stride_q    <= '0;
            ypos_q      <= '0;
            xbyte_q     <= '0;
            nbytes_q    <= '0;
            rows_left_q <= '0;
            row_addr_q  <= '0;
            cur_byte_q  <= '0;
            rem_q       <= '0;
            n_q         <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            ypos_q      <= ypos_d;
            xbyte_q     <= xbyte_d;
            nbytes_q    <= nbytes_d;
            rows_left_q <= rows_left_d;
            row_addr_q  <= row_addr_d;
            cur_byte_q  <= cur_byte_d;
            rem_q       <= rem_d;
            n_q         <= n_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign vram_req   = req_q;
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign vram_be    = be_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_vdp_super_fill.sv
`timescale 1ns/1ps
// Bench for vdp_super_fill: directed scenarios plus randomized commands against a byte-level fill model.
module tb_vdp_super_fill;
    localparam int ADDR_W = 18;

    logic              clk;
    logic              reset;
    logic              vdp_super;
    logic              super_res_drawing;
    logic              start;
    logic [16:0]       page_addr;
    logic              pixel_depth;
    logic [9:0]        line_stride, dst_x, dst_y, width, height;
    logic [7:0]        colour;
    logic              vram_req;
    logic [ADDR_W-1:0] vram_addr;
    logic [31:0]       vram_wdata;
    logic [3:0]        vram_be;
    logic              vram_ack;
    logic              busy, done;

    vdp_super_fill #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .vdp_super(vdp_super), .super_res_drawing(super_res_drawing),
        .start(start), .ext_reg_super_res_page_addr(page_addr), .ext_reg_pixel_depth(pixel_depth),
        .line_stride(line_stride), .dst_x(dst_x), .dst_y(dst_y), .width(width), .height(height),
        .colour(colour), .vram_req(vram_req), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_be(vram_be), .vram_ack(vram_ack), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [17:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  done_cnt, req_rises, proto_viol;
    int  compared, mismatched;
    bit  ack_en, ack_rand, rand_draw, rand_bit, draw_force;
    int  ack_delay;

    assign super_res_drawing = rand_draw ? rand_bit : draw_force;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rand_bit = 1'b0;
        forever begin
            @(posedge clk); #1;
            rand_bit = ($urandom_range(0, 2) == 0);
        end
    end

    // Memory side: acknowledges each request after a fixed or random number of cycles.
    initial begin
        int wc, lim;
        bit counting;
        vram_ack = 1'b0; wc = 0; lim = 0; counting = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                vram_ack = 1'b0; counting = 1'b0;
            end else if (vram_ack) begin
                vram_ack = 1'b0;
            end else if (vram_req && ack_en) begin
                if (!counting) begin
                    counting = 1'b1; wc = 0;
                    lim = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
                end
                if (wc >= lim) begin
                    vram_ack = 1'b1; counting = 1'b0;
                end else begin
                    wc++;
                end
            end
        end
    end

    // Bus monitor: logs accepted writes, done pulses, request starts and protocol breaches.
    initial begin
        bit pr, pa, pd;
        logic [17:0] pad;
        logic [3:0]  pbe;
        pr = 0; pa = 0; pd = 0; pad = '0; pbe = '0;
        done_cnt = 0; req_rises = 0; proto_viol = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pr = 0; pa = 0;
            end else begin
                if (vram_req && !pr) begin
                    req_rises++;
                    if (pd) proto_viol++;
                end
                if (pr && !pa && (!vram_req || vram_addr !== pad || vram_be !== pbe)) proto_viol++;
                if (vram_req && vram_ack) got_q.push_back('{vram_addr, vram_be, vram_wdata});
                if (done) done_cnt++;
                pr = vram_req; pa = vram_ack; pad = vram_addr; pbe = vram_be;
            end
            pd = super_res_drawing;
        end
    end

    // Reference: walk every byte of every row and group consecutive bytes of one word.
    function automatic void build_exp(input int pg, input int pd, input int st, input int x,
                                      input int y, input int w, input int h, input int col);
        int xb, nb, rb, a, k;
        bit [7:0] fb;
        bit [7:0] cb;
        wr_t e;
        exp_q.delete();
        if (w == 0 || h == 0) return;
        cb = 8'(col);
        xb = pd ? x / 2 : x;
        nb = pd ? (w + 1) / 2 : w;
        fb = pd ? {cb[3:0], cb[3:0]} : cb;
        for (int r = 0; r < h; r++) begin
            rb = pg * 8 + (y + r) * st + xb;
            for (int i = 0; i < nb; i++) begin
                a = (rb + i) & 32'hFFFFF;
                k = exp_q.size() - 1;
                if (i > 0 && exp_q[k].addr == 18'(a >> 2)) begin
                    e = exp_q[k];
                    e.be[a & 3] = 1'b1;
                    exp_q[k] = e;
                end else begin
                    e.addr = 18'(a >> 2);
                    e.be = 4'b0001 << (a & 3);
                    e.data = {4{fb}};
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    function automatic int first_diff(input int w0);
        if (got_q.size() - w0 != exp_q.size()) return -2;
        for (int i = 0; i < exp_q.size(); i++)
            if (got_q[w0 + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic issue(input int pg, input int pd, input int st, input int x, input int y,
                         input int w, input int h, input int col);
        @(posedge clk); #1;
        page_addr = 17'(pg); pixel_depth = pd[0]; line_stride = 10'(st);
        dst_x = 10'(x); dst_y = 10'(y); width = 10'(w); height = 10'(h); colour = 8'(col);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt > d0) begin ok = 1; break; end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (vram_req) begin ok = 1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({vram_req, vram_addr, vram_wdata, vram_be, busy, done} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: req=%b addr=%h data=%h be=%b busy=%b done=%b, required all 0",
                     vram_req, vram_addr, vram_wdata, vram_be, busy, done);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({vram_req, busy, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL idle_after_reset: req=%b busy=%b done=%b, required 000", vram_req, busy, done);
        end
    endtask

    task automatic test_basic;
        int d0, w0, lat, d;
        bit ok;
        d0 = done_cnt; w0 = got_q.size();
        issue(0, 0, 720, 1, 0, 6, 1, 8'h5A);
        lat = 0;
        while (!vram_req && lat < 10) begin @(posedge clk); #1; lat++; end
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL first_req_latency: %0d cycles, required 2", lat);
        end
        wait_done(d0, 100, ok);
        build_exp(0, 0, 720, 1, 0, 6, 1, 8'h5A);
        d = first_diff(w0);
        compared++;
        if (d !== -1) begin
            mismatched++;
            $display("FAIL basic_writes: idx %0d, %0d writes vs required %0d", d, got_q.size() - w0, exp_q.size());
        end
        if (got_q.size() == w0 + 2) begin
            compared++;
            if (got_q[w0 + 1].be !== 4'b0111 || got_q[w0].data !== 32'h5A5A5A5A) begin
                mismatched++;
                $display("FAIL basic_be_data: be=%b data=%h, required 0111 5a5a5a5a", got_q[w0 + 1].be, got_q[w0].data);
            end
        end
        compared++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_done: %0d pulses busy=%b, required 1 pulse busy=0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_multirow;
        int d0, w0, d;
        bit ok;
        d0 = done_cnt; w0 = got_q.size();
        issue(17'h10, 0, 720, 0, 2, 4, 3, 8'hC3);
        wait_done(d0, 200, ok);
        build_exp(17'h10, 0, 720, 0, 2, 4, 3, 8'hC3);
        d = first_diff(w0);
        compared++;
        if (d !== -1 || !ok) begin
            mismatched++;
            $display("FAIL multirow_writes: idx %0d done=%b, %0d writes vs required %0d", d, ok, got_q.size() - w0, exp_q.size());
        end
    endtask

    task automatic test_4bpp;
        int d0, w0, d;
        bit ok;
        d0 = done_cnt; w0 = got_q.size();
        issue(0, 1, 360, 3, 0, 5, 1, 8'h07);
        wait_done(d0, 100, ok);
        build_exp(0, 1, 360, 3, 0, 5, 1, 8'h07);
        d = first_diff(w0);
        compared++;
        if (d !== -1 || !ok) begin
            mismatched++;
            $display("FAIL 4bpp_writes: idx %0d done=%b, %0d writes vs required %0d", d, ok, got_q.size() - w0, exp_q.size());
        end
    endtask

    task automatic test_draw_hold;
        int d0, w0, d;
        bit ok, seen;
        d0 = done_cnt; w0 = got_q.size();
        draw_force = 1'b1;
        issue(0, 0, 720, 8, 1, 4, 1, 8'h21);
        seen = 0;
        repeat (22) begin
            @(posedge clk); #1;
            if (vram_req) seen = 1;
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL draw_hold_req: req seen=%b while drawing, required 0", seen);
        end
        draw_force = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (vram_req !== 1'b1) begin
            mismatched++;
            $display("FAIL draw_release_req: req=%b one cycle after release, required 1", vram_req);
        end
        wait_done(d0, 100, ok);
        build_exp(0, 0, 720, 8, 1, 4, 1, 8'h21);
        d = first_diff(w0);
        compared++;
        if (d !== -1 || !ok) begin
            mismatched++;
            $display("FAIL draw_hold_writes: idx %0d done=%b", d, ok);
        end
    endtask

    task automatic test_draw_in_req;
        int d0, w0, r0, p0, d;
        bit ok, seen;
        d0 = done_cnt; w0 = got_q.size(); p0 = proto_viol;
        ack_delay = 5;
        issue(0, 0, 720, 0, 0, 8, 1, 8'h99);
        wait_req(10, ok);
        draw_force = 1'b1;
        for (int i = 0; i < 20 && got_q.size() == w0; i++) begin @(posedge clk); #1; end
        compared++;
        if (got_q.size() !== w0 + 1) begin
            mismatched++;
            $display("FAIL draw_in_req_ack: %0d writes, required 1", got_q.size() - w0);
        end
        r0 = req_rises; seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (vram_req) seen = 1;
        end
        compared++;
        if (seen !== 1'b0 || req_rises !== r0) begin
            mismatched++;
            $display("FAIL draw_in_req_wait: req seen=%b rises=%0d, required 0 0", seen, req_rises - r0);
        end
        draw_force = 1'b0;
        wait_done(d0, 100, ok);
        ack_delay = 0;
        build_exp(0, 0, 720, 0, 0, 8, 1, 8'h99);
        d = first_diff(w0);
        compared++;
        if (d !== -1 || !ok || proto_viol !== p0) begin
            mismatched++;
            $display("FAIL draw_in_req_writes: idx %0d done=%b violations=%0d, required -1 1 0", d, ok, proto_viol - p0);
        end
    endtask

    task automatic test_zero;
        int d0, r0;
        for (int c = 0; c < 2; c++) begin
            d0 = done_cnt; r0 = req_rises;
            issue(0, 0, 720, 5, 5, (c == 0) ? 0 : 7, (c == 0) ? 3 : 0, 8'h11);
            compared++;
            if (done !== 1'b1) begin
                mismatched++;
                $display("FAIL zero_done_timing case %0d: done=%b one cycle after start, required 1", c, done);
            end
            repeat (4) @(posedge clk);
            #1;
            compared++;
            if (done_cnt - d0 !== 1 || req_rises !== r0) begin
                mismatched++;
                $display("FAIL zero_noop case %0d: %0d done %0d reqs, required 1 0", c, done_cnt - d0, req_rises - r0);
            end
        end
    endtask

    task automatic test_abort;
        int d0, w0, r0;
        d0 = done_cnt; w0 = got_q.size();
        issue(0, 0, 720, 0, 0, 60, 2, 8'h44);
        for (int i = 0; i < 30 && got_q.size() == w0; i++) begin @(posedge clk); #1; end
        vdp_super = 1'b0;
        r0 = req_rises;
        repeat (20) @(posedge clk);
        #1;
        compared++;
        if (got_q.size() !== w0 + 1 || req_rises !== r0 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort: %0d writes %0d later reqs %0d done busy=%b, required 1 0 1 0",
                     got_q.size() - w0, req_rises - r0, done_cnt - d0, busy);
        end
        vdp_super = 1'b1;
    endtask

    task automatic test_reset_in_req;
        int d0;
        bit ok;
        ack_en = 1'b0;
        issue(0, 0, 720, 0, 0, 16, 1, 8'h66);
        wait_req(10, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL reset_in_req_setup: req=%b, required 1", vram_req);
        end
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        compared++;
        if (vram_req !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_in_req: req=%b busy=%b right after reset, required 0 0", vram_req, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ack_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if (done_cnt !== d0 || vram_req !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_no_done: %0d done pulses req=%b, required 0 0", done_cnt - d0, vram_req);
        end
    endtask

    task automatic test_start_ignored;
        int d0, w0, r0, d;
        bit ok;
        d0 = done_cnt; w0 = got_q.size();
        issue(3, 0, 500, 2, 3, 12, 2, 8'hE1);
        repeat (3) @(posedge clk);
        issue(9, 1, 100, 7, 9, 30, 3, 8'h0B);
        wait_done(d0, 300, ok);
        build_exp(3, 0, 500, 2, 3, 12, 2, 8'hE1);
        d = first_diff(w0);
        compared++;
        if (d !== -1 || done_cnt - d0 !== 1) begin
            mismatched++;
            $display("FAIL start_while_busy: idx %0d, %0d done pulses, required -1 1", d, done_cnt - d0);
        end
        d0 = done_cnt; r0 = req_rises;
        vdp_super = 1'b0;
        issue(0, 0, 720, 0, 0, 4, 1, 8'h12);
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if (busy !== 1'b0 || req_rises !== r0 || done_cnt !== d0) begin
            mismatched++;
            $display("FAIL start_no_super: busy=%b reqs=%0d dones=%0d, required 0 0 0", busy, req_rises - r0, done_cnt - d0);
        end
        vdp_super = 1'b1;
    endtask

    task automatic test_random;
        int d0, w0, p0, d, pg, pd, st, x, y, w, h, col;
        bit ok;
        ack_rand = 1'b1; rand_draw = 1'b1;
        for (int it = 0; it < 25; it++) begin
            pg = (it % 4 == 0) ? int'($urandom_range(17'h1FF00, 17'h1FFFF)) : int'($urandom_range(0, 17'h1FFFF));
            pd = int'($urandom_range(0, 1));
            st = int'($urandom_range(1, 1023));
            x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
            w = int'($urandom_range(1, 40)); h = int'($urandom_range(1, 4));
            col = int'($urandom_range(0, 255));
            d0 = done_cnt; w0 = got_q.size(); p0 = proto_viol;
            issue(pg, pd, st, x, y, w, h, col);
            wait_done(d0, 3000, ok);
            build_exp(pg, pd, st, x, y, w, h, col);
            d = first_diff(w0);
            compared++;
            if (d !== -1 || !ok) begin
                mismatched++;
                $display("FAIL random_writes it %0d: idx %0d done=%b, %0d writes vs required %0d",
                         it, d, ok, got_q.size() - w0, exp_q.size());
            end
            compared++;
            if (proto_viol !== p0 || done_cnt - d0 !== 1) begin
                mismatched++;
                $display("FAIL random_protocol it %0d: %0d violations %0d done pulses, required 0 1",
                         it, proto_viol - p0, done_cnt - d0);
            end
        end
        ack_rand = 1'b0; rand_draw = 1'b0;
    endtask

    initial begin
        compared = 0; mismatched = 0;
        reset = 1'b1; vdp_super = 1'b1; start = 1'b0;
        page_addr = '0; pixel_depth = 1'b0; line_stride = '0;
        dst_x = '0; dst_y = '0; width = '0; height = '0; colour = '0;
        ack_en = 1'b1; ack_rand = 1'b0; ack_delay = 0; rand_draw = 1'b0; draw_force = 1'b0;
        test_reset;
        test_basic;
        test_multirow;
        test_4bpp;
        test_draw_hold;
        test_draw_in_req;
        test_zero;
        test_abort;
        test_reset_in_req;
        test_start_ignored;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vdp_super_fill.md
Name: vdp_super_fill

Overview:
- VRAM writer for the super-res framebuffer. It is the write-side counterpart of the super-res scan-out reader.
- Fills a CPU-specified rectangle with a solid colour. It packs the bytes of each row into 32-bit word writes with byte enables.
- It yields the VRAM bus whenever the scan-out arbitration flag (super_res_drawing) is high.
- It sits beside the command engine and drives the VRAM write port while scan-out is not fetching.

Parameters:
- ADDR_W, 18, VRAM word-address width (32-bit words).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vdp_super  in  1  super mode enable; low forces idle/abort
- super_res_drawing  in  1  scan-out owns the bus; no new request may start while high
- start  in  1  single-cycle pulse; latches the command registers below
- ext_reg_super_res_page_addr  in  17  page base; byte base = {page_addr,3'b000}
- ext_reg_pixel_depth  in  1  0 = 8bpp (1 px/byte), 1 = 4bpp (2 px/byte)
- line_stride  in  10  bytes per framebuffer row (720 or 360 typical)
- dst_x  in  10  left pixel
- dst_y  in  10  top row
- width  in  10  pixels per row; 0 = no-op
- height  in  10  rows; 0 = no-op
- colour  in  8  fill colour; 4bpp uses colour[3:0]
- vram_req  out  1  write request; held until vram_ack
- vram_addr  out  ADDR_W  word address
- vram_wdata  out  32  write data
- vram_be  out  4  byte enables; bit n = byte lane n
- vram_ack  in  1  write accepted this cycle
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on completion or abort

Behaviour:
- Reset values: vram_req=0, vram_addr=0, vram_wdata=0, vram_be=0, busy=0, done=0, state=IDLE.
- All command inputs are latched on start in IDLE. start is ignored while busy.
- Byte geometry:
  - 8bpp: xbyte=dst_x, nbytes=width, fill byte=colour.
  - 4bpp: xbyte=dst_x>>1, nbytes=(width+1)>>1 (dst_x[0] ignored), fill byte={colour[3:0],colour[3:0]}.
- vram_wdata = fill byte replicated 4x. It is constant for the whole command.
- Address arithmetic is 20-bit byte and truncates modulo 2^20 (wrap, no error). vram_addr = cur_byte[19:2].
- States:
  - IDLE: busy=0. On start, go to SETUP if width and height are both nonzero. Otherwise pulse done next cycle and stay IDLE.
  - SETUP (1 cycle): row_addr = base + dst_y*line_stride + xbyte (single-cycle multiply). cur_byte=row_addr, rem=nbytes, rows_left=height. Go to WAIT_BUS.
  - WAIT_BUS: stay while super_res_drawing=1. When it is 0: off=cur_byte[1:0], n=min(4-off,rem), vram_be=((1<<n)-1)<<off, vram_req=1, go to REQ.
  - REQ: hold vram_req, vram_addr, vram_be, vram_wdata stable until vram_ack. A rise of super_res_drawing while in REQ does not cancel the request.
    - On ack: vram_req=0 the next cycle, rem-=n, cur_byte+=n.
    - If rem becomes 0: go to NEXT_ROW. Otherwise go to WAIT_BUS.
  - NEXT_ROW: rows_left-=1.
    - If 0: done=1 for one cycle, go to IDLE.
    - Otherwise: row_addr+=line_stride, cur_byte=row_addr, rem=nbytes, go to WAIT_BUS.
- Request timing: the earliest vram_req is 2 cycles after start (IDLE→SETUP→WAIT_BUS). At most one request is outstanding. vram_req never asserts in a cycle where WAIT_BUS sampled super_res_drawing=1.
- vdp_super=0 in any state other than IDLE:
  - If no request is pending: immediate abort, vram_req=0, done pulse, IDLE.
  - In REQ: finish the current ack first, then abort.
- start coincident with vdp_super=0: ignored.
- Reset mid-operation: immediate return to reset values. No done pulse.

Test Plan:
- 8bpp, page=0, stride=720, x=1, y=0, w=6, h=1, colour=0x5A, bus free, ack after 1 cycle:
  - writes (addr 0, be 4'b1110, data 0x5A5A5A5A), then (addr 1, be 4'b0111).
  - done pulses once; busy low after.
- 8bpp, stride=720, x=0, y=2, w=4, h=3, page=0x00010: base byte 128.
  - word addresses 32+360=392, 572, 752, all be 4'b1111.
- 4bpp, x=3, w=5, colour=0x7 → xbyte=1, nbytes=3, data 0x77777777, single write with be 4'b1110.
- super_res_drawing high for 20 cycles while in WAIT_BUS → vram_req stays 0 for all 20 cycles, then asserts the cycle after the flag falls.
- super_res_drawing rises during REQ with ack delayed 5 cycles → vram_req held, vram_addr/vram_be stable, single completed write, then the engine waits.
- Edge cases, each checked separately:
  - width=0 → done 1 cycle later, no vram_req.
  - vdp_super dropped mid-row after an ack → done pulse, no further requests.
  - reset asserted during REQ → vram_req=0 immediately, no done pulse.
